// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states, fault causes
// and the store lane-encoding helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic ok;
    if (is_store) ok = (f3 <= F3_W);
    else          ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                       (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

  // funct3[1:0] carries the access size for both loads and stores.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'd1:    bad = off[0];
      2'd2:    bad = (off != 2'd0);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'd0:    be = 4'b0001 << off;
      2'd1:    be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3[1:0])
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[8*off +: 8];
  assign lane_h = off[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{24{lane_b[7]}}, lane_b};
      F3_H:    result = {{16{lane_h[15]}}, lane_h};
      F3_BU:   result = {24'd0, lane_b};
      F3_HU:   result = {16'd0, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: req/gnt/rvalid handshake with data memory, pipeline stall,
// bus-fault detection and a registered, aligned load result.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_valid,
  input  logic        io_is_store,
  input  logic [2:0]  io_funct3,
  input  logic [31:0] io_addr,
  input  logic [31:0] io_store_data,
  output logic        io_stall,
  output logic [31:0] io_data_mem,
  output logic        io_load_done,
  output logic        io_fault,
  output logic [1:0]  io_fault_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  state_t             state, state_nx;
  logic [2:0]         f3_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   wait_cnt;
  logic               accept, bad_f3, bad_align, start_op, timeout_hit;
  logic [31:0]        ld_result;

  assign accept      = (state == ST_IDLE) && io_valid;
  assign bad_f3      = !f3_legal(io_is_store, io_funct3);
  assign bad_align   = misaligned(io_funct3, io_addr[1:0]);
  assign start_op    = accept && !bad_f3 && !bad_align;
  // Last WAIT cycle without rvalid; rvalid in that same cycle still wins.
  assign timeout_hit = (state == ST_WAIT) && !mem_rvalid &&
                       (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign io_stall    = (state != ST_IDLE);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start_op) state_nx = ST_REQ;
      ST_REQ:  if (mem_gnt) state_nx = mem_we ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (mem_rvalid || timeout_hit) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Request stage: captured at acceptance, held stable on the bus until gnt.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_be    <= 4'd0;
      mem_wdata <= 32'd0;
      f3_q      <= 3'd0;
      off_q     <= 2'd0;
    end else if (start_op) begin
      mem_req   <= 1'b1;
      mem_we    <= io_is_store;
      mem_addr  <= {io_addr[31:2], 2'b00};
      mem_be    <= byte_enables(io_funct3, io_addr[1:0]);
      mem_wdata <= lane_data(io_funct3, io_store_data);
      f3_q      <= io_funct3;
      off_q     <= io_addr[1:0];
    end else if ((state == ST_REQ) && mem_gnt) begin
      mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                           wait_cnt <= '0;
    else if ((state == ST_REQ) && mem_gnt) wait_cnt <= '0;
    else if (state == ST_WAIT)             wait_cnt <= wait_cnt + CNT_W'(1);
  end

  load_align u_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .result (ld_result)
  );

  // Response stage: single-cycle done/fault pulses and the held load result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      io_data_mem    <= 32'd0;
      io_load_done   <= 1'b0;
      io_fault       <= 1'b0;
      io_fault_cause <= CAUSE_NONE;
    end else begin
      io_load_done   <= 1'b0;
      io_fault       <= 1'b0;
      io_fault_cause <= CAUSE_NONE;
      if (accept && bad_f3) begin
        io_fault       <= 1'b1;
        io_fault_cause <= CAUSE_ILLEGAL;
      end else if (accept && bad_align) begin
        io_fault       <= 1'b1;
        io_fault_cause <= CAUSE_MISALIGN;
      end else if ((state == ST_WAIT) && mem_rvalid) begin
        io_data_mem    <= ld_result;
        io_load_done   <= 1'b1;
      end else if (timeout_hit) begin
        io_fault       <= 1'b1;
        io_fault_cause <= CAUSE_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus randomized ops against a size/lane model.
module tb_load_store_unit;

  localparam int T = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_valid = 1'b0, io_is_store = 1'b0;
  logic [2:0]  io_funct3 = 3'd0;
  logic [31:0] io_addr = 32'd0, io_store_data = 32'd0;
  logic        io_stall, io_load_done, io_fault;
  logic [31:0] io_data_mem;
  logic [1:0]  io_fault_cause;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_data = 32'd0;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset),
    .io_valid(io_valid), .io_is_store(io_is_store), .io_funct3(io_funct3),
    .io_addr(io_addr), .io_store_data(io_store_data),
    .io_stall(io_stall), .io_data_mem(io_data_mem), .io_load_done(io_load_done),
    .io_fault(io_fault), .io_fault_cause(io_fault_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      default:    return 4;
    endcase
  endfunction

  function automatic bit ref_illegal(input bit st, input logic [2:0] f3);
    if (st) return f3 > 3'd2;
    return !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic bit ref_misaligned(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int sz = acc_size(f3);
    int off = a % 4;
    if (sz == 4) return 4'hF;
    return 4'((2 ** sz - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz = acc_size(f3);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz = acc_size(f3);
    int lane = ((a % 4) / sz) * sz;
    logic [31:0] v;
    logic [31:0] mask;
    if (sz == 4) return rd;
    mask = (sz == 1) ? 32'hFF : 32'hFFFF;
    v = (rd >> (8 * lane)) & mask;
    if (f3 < 3'd4 && v > (mask >> 1)) v = v | ~mask;
    return v;
  endfunction

  task automatic junk_inputs();
    io_valid    = 1'b1;
    io_is_store = 1'b0;
    io_funct3   = 3'd7;
    io_addr     = $urandom;
  endtask

  // Runs one op starting at a negedge with the unit idle; gd = cycles before gnt,
  // rvd = WAIT cycles before rvalid (negative: never).
  task automatic run_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] rd,
                        input int gd, input int rvd);
    check("idle_stall", io_stall, 0);
    io_valid = 1'b1; io_is_store = st; io_funct3 = f3; io_addr = a; io_store_data = d;
    @(negedge clock);
    io_valid = 1'b0;
    if (ref_illegal(st, f3) || ref_misaligned(f3, a)) begin
      check("fault", io_fault, 1);
      check("fault_cause", io_fault_cause, ref_illegal(st, f3) ? 2'b10 : 2'b01);
      check("fault_stall", io_stall, 0);
      check("fault_no_req", mem_req, 0);
      check("fault_data_held", io_data_mem, exp_data);
      return;
    end
    check("req_we", mem_we, st);
    check("req_addr", mem_addr, a & 32'hFFFF_FFFC);
    check("req_be", mem_be, ref_be(f3, a));
    if (st) check("req_wdata", mem_wdata, ref_wdata(f3, d));
    for (int i = 0; i <= gd; i++) begin
      check("req_held", mem_req, 1);
      check("req_stall", io_stall, 1);
      mem_gnt = (i == gd);
      junk_inputs();
      @(negedge clock);
    end
    mem_gnt = 1'b0;
    io_valid = 1'b0;
    check("req_dropped", mem_req, 0);
    if (st) begin
      check("store_stall_off", io_stall, 0);
      check("store_no_fault", io_fault, 0);
      return;
    end
    if (rvd >= 0) begin
      for (int k = 0; k < rvd; k++) begin
        check("wait_stall", io_stall, 1);
        check("wait_no_done", io_load_done, 0);
        mem_rdata = $urandom;
        junk_inputs();
        @(negedge clock);
      end
      mem_rvalid = 1'b1; mem_rdata = rd;
      junk_inputs();
      @(negedge clock);
      mem_rvalid = 1'b0; io_valid = 1'b0;
      exp_data = ref_load(f3, a, rd);
      check("load_done", io_load_done, 1);
      check("load_data", io_data_mem, exp_data);
      check("load_stall_off", io_stall, 0);
      check("load_no_fault", io_fault, 0);
      @(negedge clock);
      check("done_pulse_end", io_load_done, 0);
      check("data_held", io_data_mem, exp_data);
    end else begin
      for (int k = 0; k < T; k++) begin
        check("to_stall", io_stall, 1);
        check("to_no_fault", io_fault, 0);
        junk_inputs();
        @(negedge clock);
      end
      io_valid = 1'b0;
      check("to_fault", io_fault, 1);
      check("to_cause", io_fault_cause, 2'b11);
      check("to_stall_off", io_stall, 0);
      check("to_data_held", io_data_mem, exp_data);
      mem_rvalid = 1'b1; mem_rdata = ~exp_data;
      @(negedge clock);
      mem_rvalid = 1'b0;
      check("stray_ignored", io_data_mem, exp_data);
      check("stray_no_done", io_load_done, 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, io_stall, 0);
    check({tag, "_data"}, io_data_mem, 0);
    check({tag, "_done"}, io_load_done, 0);
    check({tag, "_fault"}, io_fault, 0);
    check({tag, "_cause"}, io_fault_cause, 0);
    check({tag, "_req"}, mem_req, 0);
    check({tag, "_we"}, mem_we, 0);
    check({tag, "_addr"}, mem_addr, 0);
    check({tag, "_be"}, mem_be, 0);
    check({tag, "_wdata"}, mem_wdata, 0);
  endtask

  initial begin
    logic [2:0] f3_tab [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd6};
    repeat (2) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clock);

    run_op(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0);
    check("t1_lw", io_data_mem, 32'hDEADBEEF);
    run_op(0, 3'd0, 32'h103, 0, 32'h80AA5512, 0, 0);
    check("t2_lb", io_data_mem, 32'hFFFFFF80);
    run_op(0, 3'd4, 32'h103, 0, 32'h80AA5512, 1, 2);
    check("t2_lbu", io_data_mem, 32'h00000080);
    run_op(0, 3'd1, 32'h102, 0, 32'h80AA5512, 0, 1);
    check("t2_lh", io_data_mem, 32'hFFFF80AA);
    run_op(1, 3'd0, 32'h201, 32'h123456AB, 0, 2, 0);
    run_op(0, 3'd2, 32'h102, 0, 0, 0, 0);
    run_op(0, 3'd3, 32'h100, 0, 0, 0, 0);
    run_op(1, 3'd4, 32'h100, 32'h55, 0, 0, 0);
    run_op(0, 3'd5, 32'h301, 0, 0, 0, 0);
    run_op(0, 3'd2, 32'h400, 0, 32'hCAFEF00D, 0, -1);

    // Reset while a load sits in WAIT.
    io_valid = 1'b1; io_is_store = 1'b0; io_funct3 = 3'd2; io_addr = 32'h40;
    @(negedge clock);
    io_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clock);
    mem_gnt = 1'b0;
    check("rst_pre_stall", io_stall, 1);
    #2 reset = 1'b0;
    #1 check_all_zero("midrst");
    exp_data = 32'd0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    run_op(0, 3'd2, 32'h500, 0, 32'h0BADF00D, 0, 0);

    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3 = f3_tab[$urandom_range(0, 7)];
      bit          st = $urandom_range(0, 2) == 0;
      logic [31:0] a  = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(0, 3));
      int          rvd = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 4);
      run_op(st, f3, a, $urandom, $urandom, $urandom_range(0, 3), rvd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
